// File: rtl/base_rrdemux_pkg.sv
// Shared definitions for the round-robin / priority demultiplexer.
package base_rrdemux_pkg;

  // Way-selection policies.
  localparam int unsigned MODE_PRI = 0;
  localparam int unsigned MODE_RR  = 1;

  // Index reached by stepping 'step' places past 'start' on a ring of 'n' entries.
  function automatic int unsigned rr_index(int unsigned start, int unsigned step,
                                           int unsigned n);
    return (start + step) % n;
  endfunction

endpackage

// File: rtl/base_rrdemux_rrsel.sv
// Eligible-way selector: fixed priority or pointer-rotated round-robin, one-hot grant.
module base_rrsel
  import base_rrdemux_pkg::*;
#(
  parameter int unsigned ways = 2,
  parameter int unsigned mode = MODE_PRI
) (
  input  logic [0:ways-1]         elig,
  input  logic [$clog2(ways)-1:0] ptr,
  output logic [0:ways-1]         grant,
  output logic [$clog2(ways)-1:0] idx
);

  localparam int unsigned PW = $clog2(ways);

  int unsigned j;
  logic        found;

  // Scan the ways in policy order and grant the first eligible one.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < ways; k++) begin
      if (mode == MODE_RR) begin
        // Search starts strictly after the last granted way.
        j = rr_index(int'(ptr), k + 1, ways);
      end else begin
        j = k;
      end
      if (!found && elig[j]) begin
        grant[j] = 1'b1;
        idx      = PW'(j);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/base_rrdemux.sv
// One-input, multi-way demultiplexer with a registered output slot per way.
module base_rrdemux
  import base_rrdemux_pkg::*;
#(
  parameter int unsigned ways  = 2,
  parameter int unsigned width = 1,
  parameter int unsigned mode  = MODE_PRI
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_v,
  output logic                  i_r,
  input  logic [0:width-1]      i_d,
  output logic [0:ways-1]       o_v,
  input  logic [0:ways-1]       o_r,
  output logic [0:ways*width-1] o_d
);

  localparam int unsigned PW = $clog2(ways);

  logic [0:ways-1]       v_q, v_d;
  logic [0:ways*width-1] d_q;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [0:ways-1]       elig;
  logic [0:ways-1]       grant;
  logic [PW-1:0]         sel_idx;
  logic                  accept;

  // A way can take new data if empty or if it is being drained this cycle.
  assign elig   = ~v_q | o_r;
  assign i_r    = |elig;
  assign accept = i_v & i_r;

  assign o_v = v_q;
  assign o_d = d_q;

  base_rrsel #(
    .ways (ways),
    .mode (mode)
  ) u_sel (
    .elig  (elig),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (sel_idx)
  );

  // Next-state valid bits and round-robin pointer; a load wins over a drain.
  always_comb begin
    v_d   = v_q;
    ptr_d = ptr_q;
    for (int unsigned w = 0; w < ways; w++) begin
      if (accept && grant[w]) begin
        v_d[w] = 1'b1;
      end else if (o_r[w]) begin
        v_d[w] = 1'b0;
      end
    end
    if (accept) begin
      ptr_d = sel_idx;
    end
  end

  // Valid and pointer state; reset parks the pointer on the last way so way 0 goes first.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v_q   <= '0;
      ptr_q <= PW'(ways - 1);
    end else begin
      v_q   <= v_d;
      ptr_q <= ptr_d;
    end
  end

  // Payload registers; only the granted way is written, others hold.
  always_ff @(posedge clk) begin
    for (int unsigned w = 0; w < ways; w++) begin
      if (reset_n && accept && grant[w]) begin
        d_q[w*width +: width] <= i_d;
      end
    end
  end

endmodule

// File: tb/tb_base_rrdemux.sv
// Self-checking bench: priority table, round-robin sequences, reload, reset and random run.
module tb_base_rrdemux;

  logic clk = 1'b0;
  logic rst_n;

  // Priority instance, 4 ways x 8 bits
  logic        p_iv, p_ir;
  logic [0:7]  p_id;
  logic [0:3]  p_ov, p_or;
  logic [0:31] p_od;
  // Round-robin instance, 4 ways x 8 bits
  logic        r_iv, r_ir;
  logic [0:7]  r_id;
  logic [0:3]  r_ov, r_or;
  logic [0:31] r_od;
  // Priority instance, 2 ways x 8 bits
  logic        t_iv, t_ir;
  logic [0:7]  t_id;
  logic [0:1]  t_ov, t_or;
  logic [0:15] t_od;

  int checks = 0;
  int errors = 0;

  base_rrdemux #(.ways(4), .width(8), .mode(0)) u_pri (
    .clk(clk), .reset_n(rst_n), .i_v(p_iv), .i_r(p_ir), .i_d(p_id),
    .o_v(p_ov), .o_r(p_or), .o_d(p_od)
  );
  base_rrdemux #(.ways(4), .width(8), .mode(1)) u_rr (
    .clk(clk), .reset_n(rst_n), .i_v(r_iv), .i_r(r_ir), .i_d(r_id),
    .o_v(r_ov), .o_r(r_or), .o_d(r_od)
  );
  base_rrdemux #(.ways(2), .width(8), .mode(0)) u_two (
    .clk(clk), .reset_n(rst_n), .i_v(t_iv), .i_r(t_ir), .i_d(t_id),
    .o_v(t_ov), .o_r(t_or), .o_d(t_od)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [0:7]  id;
    logic [0:3]  orr;
    logic        exp_ir;
    logic [0:3]  exp_ov;
    logic [0:31] exp_od;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic rr_drive(input logic iv, input logic [7:0] id, input logic [0:3] orr);
    @(negedge clk);
    r_iv = iv;
    r_id = id;
    r_or = orr;
    #1;
  endtask

  // Random-run model state
  logic [0:3] mval, melig, oh;
  logic [7:0] mdat[4];
  logic       mir, found;
  int         mptr, sel, jj;
  int         acc_dut, drain_dut;
  logic [0:31] eo;

  initial begin
    // Priority table: fill four ways, stall, drain/refill, reload-with-drain, drain all.
    tbl[0] = '{1'b1, 8'h11, 4'b0000, 1'b1, 4'b1000, 32'h11000000};
    tbl[1] = '{1'b1, 8'h22, 4'b0000, 1'b1, 4'b1100, 32'h11220000};
    tbl[2] = '{1'b1, 8'h33, 4'b0000, 1'b1, 4'b1110, 32'h11223300};
    tbl[3] = '{1'b1, 8'h44, 4'b0000, 1'b1, 4'b1111, 32'h11223344};
    tbl[4] = '{1'b1, 8'h55, 4'b0000, 1'b0, 4'b1111, 32'h11223344};
    tbl[5] = '{1'b0, 8'h99, 4'b0100, 1'b1, 4'b1011, 32'h11223344};
    tbl[6] = '{1'b1, 8'h66, 4'b0000, 1'b1, 4'b1111, 32'h11663344};
    tbl[7] = '{1'b1, 8'h77, 4'b0011, 1'b1, 4'b1110, 32'h11667700};
    tbl[8] = '{1'b0, 8'h88, 4'b1111, 1'b1, 4'b0000, 32'h00000000};

    rst_n = 1'b0;
    p_iv = 0; p_id = '0; p_or = '0;
    r_iv = 0; r_id = '0; r_or = '0;
    t_iv = 0; t_id = '0; t_or = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_pri_ov", 32'(p_ov), 32'h0);
    chk("reset_rr_ov", 32'(r_ov), 32'h0);
    chk("reset_two_ov", 32'(t_ov), 32'h0);
    chk("reset_pri_ir", 32'(p_ir), 32'h1);
    chk("reset_rr_ir", 32'(r_ir), 32'h1);
    chk("reset_two_ir", 32'(t_ir), 32'h1);

    // Table-driven priority checks
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      p_iv = tbl[i].iv;
      p_id = tbl[i].id;
      p_or = tbl[i].orr;
      #1;
      chk("pri_ir", 32'(p_ir), 32'(tbl[i].exp_ir));
      @(posedge clk);
      #1;
      chk("pri_ov", 32'(p_ov), 32'(tbl[i].exp_ov));
      eo = tbl[i].exp_od;
      for (int w = 0; w < 4; w++) begin
        if (tbl[i].exp_ov[w]) chk("pri_od", 32'(p_od[w*8 +: 8]), 32'(eo[w*8 +: 8]));
      end
    end
    @(negedge clk);
    p_iv = 0; p_or = '0;

    // Round-robin with all ways draining: grants 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      rr_drive(1'b1, 8'(8'hA0 + k), 4'b1111);
      chk("rr_stream_ir", 32'(r_ir), 32'h1);
      @(posedge clk);
      #1;
      oh = '0;
      oh[k % 4] = 1'b1;
      chk("rr_stream_grant", 32'(r_ov), 32'(oh));
      chk("rr_stream_od", 32'(r_od[(k % 4)*8 +: 8]), 32'(8'hA0 + k));
    end
    rr_drive(1'b0, 8'h00, 4'b1111);
    @(posedge clk); #1;
    chk("rr_drain_all", 32'(r_ov), 32'h0);

    // Fill ways 1,2,3,0 (pointer ends on 0), then drain all but way 1
    rr_drive(1'b1, 8'hB1, 4'b0000); @(posedge clk);
    rr_drive(1'b1, 8'hB2, 4'b0000); @(posedge clk);
    rr_drive(1'b1, 8'hB3, 4'b0000); @(posedge clk);
    rr_drive(1'b1, 8'hB0, 4'b0000); @(posedge clk); #1;
    chk("rr_fill_ov", 32'(r_ov), 32'hF);
    chk("rr_fill_od", r_od, 32'hB0B1B2B3);
    rr_drive(1'b0, 8'h00, 4'b1011);
    @(posedge clk); #1;
    chk("rr_partial_drain", 32'(r_ov), 32'(4'b0100));
    // ptr=0, way 1 stalled: next accept must skip to way 2
    rr_drive(1'b1, 8'hC2, 4'b0000);
    chk("rr_skip_ir", 32'(r_ir), 32'h1);
    @(posedge clk); #1;
    chk("rr_skip_ov", 32'(r_ov), 32'(4'b0110));
    chk("rr_skip_od2", 32'(r_od[16 +: 8]), 32'hC2);
    chk("rr_skip_od1", 32'(r_od[8 +: 8]), 32'hB1);

    // Reset with a concurrent acceptance and partially full ways
    rr_drive(1'b1, 8'hEE, 4'b0000);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rr_reset_ov", 32'(r_ov), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    r_iv = 1'b1; r_id = 8'hD0; r_or = '0;
    #1;
    chk("rr_post_reset_ir", 32'(r_ir), 32'h1);
    @(posedge clk); #1;
    chk("rr_post_reset_ov", 32'(r_ov), 32'(4'b1000));
    chk("rr_post_reset_od", 32'(r_od[0 +: 8]), 32'hD0);
    @(negedge clk);
    r_iv = 0;

    // Two ways: same-cycle drain and reload of way 0 without a bubble
    @(negedge clk);
    t_iv = 1'b1; t_id = 8'h5A; t_or = 2'b00;
    @(posedge clk); #1;
    chk("two_load_ov", 32'(t_ov), 32'(2'b10));
    chk("two_load_od", 32'(t_od[0 +: 8]), 32'h5A);
    @(negedge clk);
    t_iv = 1'b1; t_id = 8'hAB; t_or = 2'b10;
    #1;
    chk("two_reload_ir", 32'(t_ir), 32'h1);
    @(posedge clk); #1;
    chk("two_reload_ov", 32'(t_ov), 32'(2'b10));
    chk("two_reload_od", 32'(t_od[0 +: 8]), 32'hAB);
    @(negedge clk);
    t_iv = 0; t_or = '0;

    // Random run on the round-robin instance against a reference model
    @(negedge clk);
    rst_n = 1'b0; r_iv = 0; r_or = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mval = '0; mptr = 3; acc_dut = 0; drain_dut = 0;
    for (int w = 0; w < 4; w++) mdat[w] = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      r_iv = 1'($urandom_range(0, 1));
      r_id = 8'($urandom);
      r_or = 4'($urandom);
      #1;
      melig = ~mval | r_or;
      mir   = |melig;
      chk("rnd_ov", 32'(r_ov), 32'(mval));
      chk("rnd_ir", 32'(r_ir), 32'(mir));
      for (int w = 0; w < 4; w++) begin
        if (mval[w]) chk("rnd_od", 32'(r_od[w*8 +: 8]), 32'(mdat[w]));
        if (r_ov[w] && r_or[w]) drain_dut++;
      end
      if (r_iv && r_ir) acc_dut++;
      // Model next state
      found = 1'b0;
      sel = 0;
      for (int k = 1; k <= 4; k++) begin
        jj = (mptr + k) % 4;
        if (!found && melig[jj]) begin
          sel = jj;
          found = 1'b1;
        end
      end
      for (int w = 0; w < 4; w++) begin
        if (mval[w] && r_or[w]) mval[w] = 1'b0;
      end
      if (r_iv && mir) begin
        mval[sel] = 1'b1;
        mdat[sel] = r_id;
        mptr = sel;
      end
    end
    @(negedge clk);
    r_iv = 0; r_or = '0;
    #1;
    // Every accepted payload is either drained once or still held
    chk("rnd_conservation", 32'(acc_dut), 32'(drain_dut + $countones(r_ov)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/base_rrdemux.md
BASE_RRDEMUX -- requirements
Module: base_rrdemux

Interface
REQ-001 SHALL have parameter ways, default 2: number of output ways, minimum 2.
REQ-002 SHALL have parameter width, default 1: payload width in bits.
REQ-003 SHALL have parameter mode, default 0: way-selection policy, 0 = fixed priority (lowest index first), 1 = round-robin.
REQ-004 SHALL have port clk  input  1  the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port i_v  input  1  input valid.
REQ-007 SHALL have port i_r  output  1  input ready.
REQ-008 SHALL have port i_d  input  [0:width-1]  input payload.
REQ-009 SHALL have port o_v  output  [0:ways-1]  per-way output valid.
REQ-010 SHALL have port o_r  input  [0:ways-1]  per-way output ready.
REQ-011 SHALL have port o_d  output  [0:ways*width-1]  per-way payload; way w occupies bits [w*width : w*width+width-1].

Function
REQ-012 SHALL hold one output register per way (valid bit plus width-bit payload); o_v and o_d are driven directly from these registers.
REQ-013 SHALL treat way w as eligible in a cycle when its register is empty or o_r[w] is 1 in that cycle.
REQ-014 SHALL drive i_r = OR of all eligible bits, combinationally; i_r does not depend on i_v.
REQ-015 SHALL accept the input when i_v & i_r, and write i_d into exactly one selected eligible way, visible on o_v/o_d the next cycle (latency 1).
REQ-016 SHALL, with mode 0, select the lowest-index eligible way.
REQ-017 SHALL, with mode 1, select the first eligible way at index strictly greater than ptr, wrapping to index 0 after ways-1.
REQ-018 SHALL keep round-robin pointer ptr of width clog2(ways); on acceptance ptr <= selected index; otherwise ptr holds.
REQ-019 SHALL clear way w's valid on o_v[w] & o_r[w], unless the same cycle's acceptance selects w, in which case valid stays 1 and the payload is replaced (no bubble).
REQ-020 SHALL keep a way's payload and valid stable while o_v[w] = 1 and o_r[w] = 0.
REQ-021 SHALL leave all registers unchanged when i_v = 0 and no way drains.
REQ-022 SHALL not write any way when i_v = 1 and i_r = 0 (all ways full and stalled).
REQ-023 SHALL allow any number of ways to drain in the same cycle.
REQ-024 SHALL ignore i_d when no acceptance occurs; o_d of an empty way holds its previous value.

Reset
REQ-025 SHALL, while reset_n = 0 at a clock edge, clear every way's valid bit (o_v = 0) and set ptr = ways-1, so that index 0 is the first round-robin choice.
REQ-026 SHALL let reset_n = 0 override any concurrent acceptance or drain in that cycle; payload registers need not be reset.
REQ-027 SHALL leave i_r combinationally determined by state, so i_r = 1 in the first cycle after reset.

Structure
REQ-028 SHALL take the mode encodings (MODE_PRI = 0, MODE_RR = 1) from the shared base package, not local literals.
REQ-029 SHALL place the eligible-way selection (priority or pointer-rotated, one-hot grant output) in one sub-module, base_rrsel, parameterised by ways and mode.
REQ-030 SHALL contain no combinational path from i_v to o_v or o_d.

Verification
REQ-031 SHALL cover: ways=4, mode 0, all o_r=0, four accepts of 0x11,0x22,0x33,0x44 -> ways 0..3 filled in order; fifth i_v sees i_r=0; o_d unchanged.
REQ-032 SHALL cover: ways=4, mode 1, all o_r=1, continuous i_v -> grants 0,1,2,3,0 on consecutive cycles; i_r=1 every cycle.
REQ-033 SHALL cover: ways=4, mode 1, way 1 full with o_r[1]=0, ptr=0 -> next accept goes to way 2; way 1 payload held.
REQ-034 SHALL cover: ways=2, way 0 full, o_r[0]=1 and i_v=1 with 0xAB in the same cycle, mode 0 -> way 0 reloads 0xAB, o_v[0] stays 1.
REQ-035 SHALL cover: reset_n=0 asserted while i_v=1 and ways partially full -> next cycle o_v=0 and the first mode-1 grant goes to way 0.
REQ-036 SHALL cover: random i_v/o_r over 10000 cycles against a scoreboard -> every accepted payload appears exactly once on the selected way; no loss, duplication or reordering within a way.
